// File: rtl/tiny_cpu_pkg.sv
// Shared Tiny-CPU definitions: sequencer states, the HALT opcode and the
// opcode values understood by the instruction decoder.
package tiny_cpu_pkg;

    localparam logic [3:0] HALT_OPCODE = 4'hF;

    // Decoder opcodes 0..12; 13 and 14 are unassigned, 15 is HALT.
    localparam logic [3:0] OPC_NOP   = 4'h0;
    localparam logic [3:0] OPC_LDA   = 4'h1;
    localparam logic [3:0] OPC_LDB   = 4'h2;
    localparam logic [3:0] OPC_ADD   = 4'h3;
    localparam logic [3:0] OPC_SUB   = 4'h4;
    localparam logic [3:0] OPC_AND   = 4'h5;
    localparam logic [3:0] OPC_OR    = 4'h6;
    localparam logic [3:0] OPC_XOR   = 4'h7;
    localparam logic [3:0] OPC_NOT   = 4'h8;
    localparam logic [3:0] OPC_SHL   = 4'h9;
    localparam logic [3:0] OPC_SHR   = 4'hA;
    localparam logic [3:0] OPC_OUT   = 4'hB;
    localparam logic [3:0] OPC_JMP   = 4'hC;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        EXEC      = 3'd2,
        WAIT_STEP = 3'd3,
        HALTED    = 3'd4
    } seq_state_e;

endpackage

// File: rtl/program_store.sv
// Program memory for the sequencer: register array with synchronous write,
// combinational read, and every word reset to the HALT opcode.
module program_store
    import tiny_cpu_pkg::*;
#(
    parameter int                ADDR_W     = 4,
    parameter int                DATA_W     = 4,
    parameter logic [DATA_W-1:0] RESET_WORD = DATA_W'(HALT_OPCODE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next contents: one word replaced when a write is accepted.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage array, cleared to RESET_WORD so an unloaded program halts at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_WORD;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch stage for the Tiny-CPU: walks the program store, presents one opcode at
// a time to the decoder, with free-run, single-step, stop and HALT handling.
module instruction_sequencer #(
    parameter int                ADDR_W      = 4,
    parameter int                DATA_W      = 4,
    parameter int                HOLD_CYCLES = 1,
    parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(tiny_cpu_pkg::HALT_OPCODE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              step_mode,
    input  logic              step,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    import tiny_cpu_pkg::*;

    localparam int               HOLD_W    = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instruction_q, instruction_d;
    logic              instr_valid_q, instr_valid_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;

    logic              store_we_s;
    logic              stop_take_s;
    logic [DATA_W-1:0] store_rdata_s;

    // The store is writable only while no program is being sequenced.
    assign store_we_s  = prog_we && ((state_q == IDLE) || (state_q == HALTED));
    assign stop_take_s = stop && (state_q != IDLE);

    program_store #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RESET_WORD (HALT_OPCODE)
    ) u_store (
        .clk   (clk),
        .reset (reset),
        .we    (store_we_s),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (store_rdata_s)
    );

    // Next-state, pc, hold counter and opcode; stop overrides every state.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instruction_d = instruction_q;
        hold_d        = hold_q;
        instr_valid_d = 1'b0;
        if (stop_take_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        pc_d    = {ADDR_W{1'b0}};
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FETCH: begin
                    if (store_rdata_s == HALT_OPCODE) begin
                        state_d = HALTED;
                    end else begin
                        instruction_d = store_rdata_s;
                        hold_d        = {HOLD_W{1'b0}};
                        state_d       = EXEC;
                    end
                end
                EXEC: begin
                    // instr_valid is registered, so it trails the EXEC cycles by one.
                    instr_valid_d = 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = step_mode ? WAIT_STEP : FETCH;
                    end else begin
                        hold_d  = hold_q + HOLD_W'(1);
                    end
                end
                WAIT_STEP: begin
                    if (step) begin
                        state_d = FETCH;
                    end else begin
                        state_d = WAIT_STEP;
                    end
                end
                HALTED: begin
                    if (start) begin
                        pc_d    = {ADDR_W{1'b0}};
                        state_d = FETCH;
                    end else begin
                        state_d = HALTED;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d   = (state_d == FETCH) || (state_d == EXEC) || (state_d == WAIT_STEP);
        halted_d = (state_d == HALTED);
    end

    // State, pc, opcode and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= {ADDR_W{1'b0}};
            instruction_q <= {DATA_W{1'b0}};
            instr_valid_q <= 1'b0;
            hold_q        <= {HOLD_W{1'b0}};
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
            hold_q        <= hold_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
        end
    end

    assign instruction = instruction_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign halted      = halted_q;

endmodule
